fcmp_pipe: RTL and testbench
============================

Name: fcmp_pipe

Overview:
Parametrised, pipelined floating-point comparator that generalises the single-mode combinational less-than unit.
- Modes: feq, flt, fle.
- Zero handling: signed-zero equality.
- NaN handling: NaN detection with an invalid flag.
- Interface: valid/ready elastic pipeline of configurable depth.
- Placement: FPU execute path; result returned to the integer register file (0/1 in LSB).

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
STAGES, 2, pipeline depth 1..3 (latency in cycles)
NAN_AWARE, 1, 1 = IEEE NaN semantics; 0 = NaN inputs treated as ordinary encodings (legacy-compatible, nv always 0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  unit accepts operands this cycle
op  in  2  00 feq, 01 flt, 10 fle, 11 reserved
x  in  W  operand x
y  in  W  operand y
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
res  out  W  {W-1 zeros, cmp bit}
nv  out  1  invalid-operation flag, qualified by out_valid

Behaviour:
- Reset (rst high at posedge): all stage valid bits cleared.
  - out_valid=0, res=0, nv=0.
  - in_ready=1 in the first cycle after reset.
  - A transaction in flight when reset is asserted is discarded; no output is produced for it.
- Global advance enable: en = !out_valid | out_ready.
  - in_ready = en.
  - All stages shift only when en=1.
  - Bubbles are not collapsed; no combinational path from in_valid to out_valid.
- Transfer rules:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - res and nv hold stable while out_valid & !out_ready.
- Latency: exactly STAGES cycles from accepted input to out_valid with no stall.
  - Throughput: 1 per cycle when out_ready stays high.
- Stage 1 (always registered):
  - Decode sign/exp/man.
  - Classify: zero = exp==0 & man==0; NaN = exp all-ones & man!=0; sNaN = NaN & man MSB==0.
  - Compute magnitude compare on {exp,man} as an unsigned (W-1)-bit subtract: lt_mag, eq_mag.
- Final stage: sign resolution.
  - Both zero (any signs): equal, not less.
  - Signs differ: x<y iff sx=1.
  - Both positive: x<y iff lt_mag.
  - Both negative: x<y iff !lt_mag & !eq_mag.
  - eq = eq_mag & sx==sy, or both zero.
- For STAGES=3, an intermediate register sits between magnitude compare and sign resolution. For STAGES=1, stage 1 outputs directly.
- NaN (NAN_AWARE=1):
  - Any NaN operand: cmp=0.
  - flt/fle: nv=1 on any NaN.
  - feq: nv=1 only on sNaN.
- NAN_AWARE=0: NaN bit patterns compared by sign/magnitude as above; nv=0.
- op=11: cmp=0, nv=0, still produces a valid result (no hang).
- Infinities compare as ordinary encodings (+inf > all finite). Denormals compare by bit pattern (no flush).

Decomposition:
- Shared package fpu_pkg:
  - op encodings FCMP_EQ/FCMP_LT/FCMP_LE.
  - class record type {sign, is_zero, is_nan, is_snan}.
  - W derivation helper.
- One natural sub-module: fcmp_classify (combinational operand classifier), reused by fclass/fmin/fmax later.

Test Plan:
1. flt x=0xBF800000(-1.0) y=0x3F800000(1.0), STAGES=2 -> out_valid exactly 2 cycles after accept, res=1, nv=0.
2. feq x=0x80000000 y=0x00000000 -> res=1; flt same operands -> res=0; fle -> res=1.
3. Negative ordering: flt x=0xC0000000(-2.0) y=0xBF800000(-1.0) -> res=1; swapped -> res=0; equal exponents with mantissa differing in the LSB are covered in both signs.
4. NaN handling:
   - flt x=0x7FC00000 (qNaN) y=0x3F800000 -> res=0, nv=1.
   - feq same operands -> res=0, nv=0.
   - feq x=0x7F800001 (sNaN) -> res=0, nv=1.
   - NAN_AWARE=0 with qNaN in the flt case -> res=0, nv=0.
5. Back-to-back stream of 8 ops with out_ready held low for cycles 3-5:
   - in_ready=0 while stalled.
   - res and nv stable during the stall.
   - All 8 results emitted in order with none lost or duplicated.
6. rst asserted with 2 ops in flight -> next cycle out_valid=0, res=0, in_ready=1; no stale result emerges later. Repeat for STAGES=1 and STAGES=3.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: comparison opcodes, operand class record, word-width helper
// and the sign-resolution function used by the comparator pipeline.
package fpu_pkg;

    localparam logic [1:0] FCMP_EQ = 2'b00;
    localparam logic [1:0] FCMP_LT = 2'b01;
    localparam logic [1:0] FCMP_LE = 2'b10;

    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_nan;
        logic is_snan;
    } fcls_t;

    // Everything the final stage needs; independent of the operand width.
    typedef struct packed {
        logic [1:0] op;
        fcls_t      cx;
        fcls_t      cy;
        logic       lt_mag;
        logic       eq_mag;
    } fcmp_stage_t;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Returns {cmp, nv}.
    function automatic logic [1:0] fcmp_resolve(input fcmp_stage_t s, input logic nan_aware);
        logic both_zero;
        logic lt;
        logic eq;
        logic any_nan;
        logic any_snan;
        logic cmp;
        logic nv;
        both_zero = s.cx.is_zero & s.cy.is_zero;
        if (both_zero)
            lt = 1'b0;
        else if (s.cx.sign != s.cy.sign)
            lt = s.cx.sign;
        else if (!s.cx.sign)
            lt = s.lt_mag;
        else
            lt = !s.lt_mag & !s.eq_mag;
        eq       = both_zero | (s.eq_mag & (s.cx.sign == s.cy.sign));
        any_nan  = nan_aware & (s.cx.is_nan | s.cy.is_nan);
        any_snan = nan_aware & (s.cx.is_snan | s.cy.is_snan);
        case (s.op)
            FCMP_EQ: begin cmp = eq;      nv = any_snan; end
            FCMP_LT: begin cmp = lt;      nv = any_nan;  end
            FCMP_LE: begin cmp = lt | eq; nv = any_nan;  end
            default: begin cmp = 1'b0;    nv = 1'b0;     end
        endcase
        if (any_nan)
            cmp = 1'b0;
        return {cmp, nv};
    endfunction

endpackage

// File: rtl/fcmp_classify.sv
// Combinational operand classifier: sign, zero, NaN and signalling-NaN detection.
module fcmp_classify
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_word,
    output fcls_t                o_cls
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;

    assign w_exp = i_word[MAN_W +: EXP_W];
    assign w_man = i_word[MAN_W-1:0];

    always_comb begin
        o_cls         = '0;
        o_cls.sign    = i_word[EXP_W+MAN_W];
        o_cls.is_zero = (w_exp == '0) && (w_man == '0);
        o_cls.is_nan  = (&w_exp) && (|w_man);
        // Quiet NaNs carry the mantissa MSB set; a clear MSB marks a signalling NaN.
        o_cls.is_snan = (&w_exp) && (|w_man) && !w_man[MAN_W-1];
    end

endmodule

// File: rtl/fcmp_pipe.sv
// Pipelined floating-point comparator (feq/flt/fle) with an elastic valid/ready
// interface of STAGES cycles latency; the result bit lands in res[0].
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int STAGES    = 2,
    parameter int NAN_AWARE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [EXP_W+MAN_W:0] x,
    input  logic [EXP_W+MAN_W:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] res,
    output logic                 nv
);

    localparam int   W      = fp_width(EXP_W, MAN_W);
    localparam int   M      = W - 1;
    localparam logic C_NAN  = (NAN_AWARE != 0);

    // Handshake: a word moves on any edge where valid & ready are both high.
    // The whole pipe advances together on en = !out_valid | out_ready, so
    // in_ready equals en, bubbles are kept, and res/nv hold while stalled.
    logic w_en;

    fcls_t       w_cx;
    fcls_t       w_cy;
    logic [M:0]  w_diff;
    fcmp_stage_t w_s1_d;
    fcmp_stage_t r_s1;
    logic        r_v1;

    fcmp_stage_t w_mid_s;
    logic        w_mid_v;
    logic        w_fin_v;
    logic        w_fin_cmp;
    logic        w_fin_nv;

    assign w_en     = !w_fin_v | out_ready;
    assign in_ready = w_en;

    fcmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (.i_word(x), .o_cls(w_cx));
    fcmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (.i_word(y), .o_cls(w_cy));

    // {exp,man} ordered as an unsigned integer; the borrow bit is the less-than.
    assign w_diff = {1'b0, x[M-1:0]} - {1'b0, y[M-1:0]};

    always_comb begin
        w_s1_d        = '0;
        w_s1_d.op     = op;
        w_s1_d.cx     = w_cx;
        w_s1_d.cy     = w_cy;
        w_s1_d.lt_mag = w_diff[M];
        w_s1_d.eq_mag = (x[M-1:0] == y[M-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_s1 <= w_s1_d;
        end
    end

    if (STAGES >= 3) begin : g_mid
        fcmp_stage_t r_s2;
        logic        r_v2;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v2 <= 1'b0;
                r_s2 <= '0;
            end else if (w_en) begin
                r_v2 <= r_v1;
                r_s2 <= r_s1;
            end
        end
        assign w_mid_v = r_v2;
        assign w_mid_s = r_s2;
    end else begin : g_nomid
        assign w_mid_v = r_v1;
        assign w_mid_s = r_s1;
    end

    if (STAGES >= 2) begin : g_out
        logic [1:0] w_rs;
        logic       r_vo;
        logic       r_cmp;
        logic       r_nv;
        assign w_rs = fcmp_resolve(w_mid_s, C_NAN);
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vo  <= 1'b0;
                r_cmp <= 1'b0;
                r_nv  <= 1'b0;
            end else if (w_en) begin
                r_vo  <= w_mid_v;
                r_cmp <= w_rs[1];
                r_nv  <= w_rs[0];
            end
        end
        assign w_fin_v   = r_vo;
        assign w_fin_cmp = r_cmp;
        assign w_fin_nv  = r_nv;
    end else begin : g_comb
        logic [1:0] w_rs;
        assign w_rs      = fcmp_resolve(w_mid_s, C_NAN);
        assign w_fin_v   = w_mid_v;
        assign w_fin_cmp = w_rs[1];
        assign w_fin_nv  = w_rs[0];
    end

    // Bubble slots carry stale data; gating keeps res/nv at zero when idle.
    assign out_valid = w_fin_v;
    assign res       = {{(W-1){1'b0}}, w_fin_v & w_fin_cmp};
    assign nv        = w_fin_v & w_fin_nv;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: four instances (STAGES 2/1/3 NaN-aware, STAGES 2 legacy)
// share one stimulus stream; each has its own expected queue fed on accept.
module tb_fcmp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;

    logic        ir  [4];
    logic        ov  [4];
    logic [31:0] rs  [4];
    logic        nvo [4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [31:0] pool [16] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                               32'h3F800001, 32'hBF800001, 32'h7F800000, 32'hFF800000,
                               32'h00000001, 32'h80000001, 32'h7FC00000, 32'h7F800001,
                               32'hFFC00000, 32'h40000000, 32'hC0000000, 32'h007FFFFF};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int st_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 3 : 2;
    endfunction

    // Reference: map sign/magnitude onto a signed integer line (both zeros land on 0).
    function automatic logic [32:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input bit aware);
        longint ka;
        longint kb;
        logic na, nb, sa, sb, lt, eq, c, v;
        ka = {33'b0, a[30:0]};
        kb = {33'b0, b[30:0]};
        if (a[31]) ka = -ka;
        if (b[31]) kb = -kb;
        na = aware && (a[30:23] == 8'hFF) && (a[22:0] != '0);
        nb = aware && (b[30:23] == 8'hFF) && (b[22:0] != '0);
        sa = na && !a[22];
        sb = nb && !b[22];
        lt = (ka < kb);
        eq = (ka == kb);
        case (o)
            2'd0:    begin c = eq;      v = sa || sb; end
            2'd1:    begin c = lt;      v = na || nb; end
            2'd2:    begin c = lt || eq; v = na || nb; end
            default: begin c = 1'b0;    v = 1'b0;    end
        endcase
        if (na || nb) c = 1'b0;
        return {v, 31'b0, c};
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int ST = st_of(k);
        localparam int NA = (k == 3) ? 0 : 1;
        logic [32:0] exp_q[$];
        logic [32:0] e;
        int          pend = 0;
        int          stall_seen = 0;
        logic        prev_stall;
        logic [31:0] prev_res;
        logic        prev_nv;

        fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(ST), .NAN_AWARE(NA)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[k]), .op(op),
            .x(x), .y(y), .out_valid(ov[k]), .out_ready(out_ready), .res(rs[k]), .nv(nvo[k])
        );

        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (ov[k] && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL dut%0d unexpected_output res=%h nv=%b expected none", k, rs[k], nvo[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if (rs[k] !== e[31:0] || nvo[k] !== e[32]) begin
                            errors++;
                            $display("FAIL dut%0d result got res=%h nv=%b expected res=%h nv=%b",
                                     k, rs[k], nvo[k], e[31:0], e[32]);
                        end
                    end
                end
                if (ov[k] && !out_ready) begin
                    stall_seen++;
                    checks++;
                    if (ir[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL dut%0d stall_in_ready got %b expected 0", k, ir[k]);
                    end
                    if (prev_stall) begin
                        checks++;
                        if (rs[k] !== prev_res || nvo[k] !== prev_nv) begin
                            errors++;
                            $display("FAIL dut%0d stall_hold got res=%h nv=%b expected res=%h nv=%b",
                                     k, rs[k], nvo[k], prev_res, prev_nv);
                        end
                    end
                end
                if (in_valid && ir[k])
                    exp_q.push_back(model(op, x, y, NA != 0));
                prev_stall = ov[k] && !out_ready;
                prev_res   = rs[k];
                prev_nv    = nvo[k];
            end
            pend = exp_q.size();
        end
    end

    // Driver: holds the operand pair until the reference instance (dut0) takes it.
    task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        op       = o;
        x        = a;
        y        = b;
        @(negedge clk);
        while (!ir[0] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!ir[0]) begin
            errors++;
            $display("FAIL send_accept in_ready got %b expected 1 within 50 cycles", ir[0]);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        int i;
        i = $urandom_range(0, 16);
        return (i == 16) ? $urandom : pool[i];
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks += 4;
            if (ov[k] !== 1'b0) begin errors++; $display("FAIL dut%0d reset_out_valid got %b expected 0", k, ov[k]); end
            if (rs[k] !== 32'h0) begin errors++; $display("FAIL dut%0d reset_res got %h expected 0", k, rs[k]); end
            if (nvo[k] !== 1'b0) begin errors++; $display("FAIL dut%0d reset_nv got %b expected 0", k, nvo[k]); end
            if (ir[k] !== 1'b1) begin errors++; $display("FAIL dut%0d reset_in_ready got %b expected 1", k, ir[k]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_latency;
        int lat [4];
        int a;
        for (int k = 0; k < 4; k++) lat[k] = -1;
        send(2'd1, 32'hBF800000, 32'h3F800000);
        a = acc_cyc;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (ov[k] && lat[k] < 0) lat[k] = cyc - a;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lat[k] !== st_of(k)) begin
                errors++;
                $display("FAIL dut%0d latency got %0d expected %0d", k, lat[k], st_of(k));
            end
        end
    endtask

    task automatic test_zero;
        send(2'd0, 32'h80000000, 32'h00000000);
        send(2'd1, 32'h80000000, 32'h00000000);
        send(2'd2, 32'h80000000, 32'h00000000);
        send(2'd1, 32'h00000000, 32'h80000000);
        send(2'd1, 32'h80000000, 32'h00000001);
        for (int c = 0; c < 20 && g_dut[0].pend != 0; c++) @(negedge clk);
        checks++;
        if (g_dut[0].pend != 0) begin errors++; $display("FAIL zero_drain pending got %0d expected 0", g_dut[0].pend); end
    endtask

    task automatic test_negative;
        logic [31:0] ta [8] = '{32'hC0000000, 32'hBF800000, 32'hBF800001, 32'hBF800000,
                                32'h3F800000, 32'h3F800001, 32'hFF800000, 32'h00000001};
        logic [31:0] tb [8] = '{32'hBF800000, 32'hC0000000, 32'hBF800000, 32'hBF800001,
                                32'h3F800001, 32'h3F800000, 32'hC0000000, 32'h7F800000};
        for (int i = 0; i < 8; i++) send(2'd1, ta[i], tb[i]);
        send(2'd2, 32'hBF800001, 32'hBF800001);
        send(2'd0, 32'hBF800001, 32'hBF800000);
        for (int c = 0; c < 20 && g_dut[0].pend != 0; c++) @(negedge clk);
        checks++;
        if (g_dut[0].pend != 0) begin errors++; $display("FAIL negative_drain pending got %0d expected 0", g_dut[0].pend); end
    endtask

    task automatic test_nan;
        send(2'd1, 32'h7FC00000, 32'h3F800000);
        send(2'd0, 32'h7FC00000, 32'h3F800000);
        send(2'd0, 32'h7F800001, 32'h3F800000);
        send(2'd2, 32'h3F800000, 32'hFFC00000);
        send(2'd0, 32'h7FC00000, 32'h7FC00000);
        send(2'd3, 32'h7F800001, 32'h3F800000);
        send(2'd3, 32'h3F800000, 32'h3F800000);
        for (int c = 0; c < 20 && g_dut[0].pend != 0; c++) @(negedge clk);
        checks++;
        if (g_dut[0].pend != 0) begin errors++; $display("FAIL nan_drain pending got %0d expected 0", g_dut[0].pend); end
    endtask

    task automatic test_back_to_back;
        int s0;
        s0 = g_dut[0].stall_seen;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(2'($urandom_range(0, 2)), pick(), pick());
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 20 && g_dut[0].pend != 0; c++) @(negedge clk);
        checks += 2;
        if (g_dut[0].stall_seen == s0) begin errors++; $display("FAIL b2b_stall_seen got 0 stalled cycles expected >0"); end
        if (g_dut[0].pend != 0) begin errors++; $display("FAIL b2b_drain pending got %0d expected 0", g_dut[0].pend); end
    endtask

    task automatic test_random;
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    send(2'($urandom_range(0, 3)), pick(), pick());
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
    endtask

    task automatic test_reset_inflight;
        send(2'd1, 32'hBF800000, 32'h3F800000);
        send(2'd2, 32'h3F800000, 32'h3F800000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (ov[k] !== 1'b0) begin errors++; $display("FAIL dut%0d flush_out_valid got %b expected 0", k, ov[k]); end
            if (rs[k] !== 32'h0) begin errors++; $display("FAIL dut%0d flush_res got %h expected 0", k, rs[k]); end
            if (ir[k] !== 1'b1) begin errors++; $display("FAIL dut%0d flush_in_ready got %b expected 1", k, ir[k]); end
        end
        repeat (6) @(negedge clk);
        send(2'd0, 32'h3F800000, 32'h3F800000);
    endtask

    task automatic test_drain;
        for (int c = 0; c < 30; c++) @(negedge clk);
        checks += 4;
        if (g_dut[0].pend != 0) begin errors++; $display("FAIL dut0 final_pending got %0d expected 0", g_dut[0].pend); end
        if (g_dut[1].pend != 0) begin errors++; $display("FAIL dut1 final_pending got %0d expected 0", g_dut[1].pend); end
        if (g_dut[2].pend != 0) begin errors++; $display("FAIL dut2 final_pending got %0d expected 0", g_dut[2].pend); end
        if (g_dut[3].pend != 0) begin errors++; $display("FAIL dut3 final_pending got %0d expected 0", g_dut[3].pend); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'd0;
        x         = 32'h0;
        y         = 32'h0;
        test_reset;
        test_latency;
        test_zero;
        test_negative;
        test_nan;
        test_back_to_back;
        test_random;
        test_reset_inflight;
        test_drain;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
